// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IMEM addressing, IF/ID register with valid/ready to decode.
// Optional perf counters are built only when FETCH_PERF_EN is defined (ports are tied to 0 otherwise).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 512,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic        halted_q,   halted_d;
  logic        misalign_q, misalign_d;
  logic        fetch_slot;
  logic        capture;

  // A zero word or an address past the end of IMEM stops the fetch stream.
  function automatic logic bad_fetch(input logic [31:0] inst, input logic [31:0] pc);
    return (inst == 32'h0) || (pc >= PC_LIMIT);
  endfunction

  assign fetch_slot = (state_q == S_RUN) && (!id_valid_q || id_ready);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    misalign_d = 1'b0;
    capture    = 1'b0;

    if (redirect_valid) begin
      // Redirect beats everything, including a stalled instruction in IF/ID.
      id_valid_d = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = S_RUN;
      end else begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (fetch_slot) begin
            if (bad_fetch(imem_inst, pc_q)) begin
              id_valid_d = 1'b0;
              state_d    = S_HALT;
            end else begin
              capture    = 1'b1;
              id_inst_d  = imem_inst;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'h0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_valid     = id_valid_q;
  assign id_inst      = id_inst_q;
  assign id_pc        = id_pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (capture)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (id_valid_q && !id_ready)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule
